// File: rtl/tt_pkg.sv
// Shared definitions for the truth-table scanner: scan state encoding and
// the truth-table width derived from the evaluator input count.
package tt_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EVAL = 2'd1,
      ST_DONE = 2'd2
   } tt_state_t;

   // Width of a full truth table for n boolean inputs.
   function automatic int tt_width(input int n);
      return 1 << n;
   endfunction

endpackage

// File: rtl/tt_popcount.sv
// Combinational population count of a truth table, used for the optional
// ones counter of the scanner.
module tt_popcount #(
   parameter int IN_W  = 8,
   parameter int OUT_W = 4
) (
   input  logic [IN_W-1:0]  bits,
   output logic [OUT_W-1:0] cnt
);

   always_comb begin
      cnt = '0;
      for (int i = 0; i < IN_W; i++) begin
         cnt = cnt + OUT_W'(bits[i]);
      end
   end

endmodule

// File: rtl/truth_table_scanner.sv
// Sweeps every input vector of an external boolean evaluator, captures its
// truth table and compares it against an expected minterm mask.
// Optional popcount output is built when TT_ONES_COUNT_EN is defined.
module truth_table_scanner
   import tt_pkg::*;
#(
   parameter  int N_VARS = 3,
   parameter  int SETTLE = 0,
   localparam int TT_W   = tt_width(N_VARS)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [TT_W-1:0]   mask,
   output logic [N_VARS-1:0] vec,
   input  logic              s_in,
   output logic              busy,
   output logic              done,
   output logic [TT_W-1:0]   tt_table,
   output logic              match
`ifdef TT_ONES_COUNT_EN
   ,
   output logic [N_VARS:0]   ones_cnt
`endif
);

   localparam logic [N_VARS-1:0] VEC_LAST  = N_VARS'(TT_W - 1);
   localparam logic [3:0]        SETTLE_CY = 4'(SETTLE);

   tt_state_t         state;
   logic [3:0]        wcnt;
   logic [TT_W-1:0]   mask_q;
   logic [TT_W-1:0]   table_nxt;
   logic              capture;
   logic              cap_last;

   // Capture happens once the settle wait for the current vector is over.
   assign capture  = (state == ST_EVAL) && (wcnt == SETTLE_CY);
   assign cap_last = capture && (vec == VEC_LAST);

   always_comb begin
      table_nxt      = tt_table;
      table_nxt[vec] = s_in;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= ST_IDLE;
         vec      <= '0;
         wcnt     <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         tt_table <= '0;
         match    <= 1'b0;
         mask_q   <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  mask_q   <= mask;
                  tt_table <= '0;
                  vec      <= '0;
                  wcnt     <= '0;
                  busy     <= 1'b1;
                  state    <= ST_EVAL;
               end
            end
            ST_EVAL: begin
               if (!capture) begin
                  wcnt <= wcnt + 4'd1;
               end else begin
                  wcnt     <= '0;
                  tt_table <= table_nxt;
                  // Wraps to 0 on the last vector, leaving vec idle at 0.
                  vec      <= vec + 1'b1;
                  if (cap_last) begin
                     // Outputs become valid together with the done pulse.
                     busy  <= 1'b0;
                     done  <= 1'b1;
                     match <= (table_nxt == mask_q);
                     state <= ST_DONE;
                  end
               end
            end
            ST_DONE: begin
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

`ifdef TT_ONES_COUNT_EN
   logic [N_VARS:0] pop_nxt;

   tt_popcount #(
      .IN_W  (TT_W),
      .OUT_W (N_VARS + 1)
   ) u_popcount (
      .bits (table_nxt),
      .cnt  (pop_nxt)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         ones_cnt <= '0;
      end else if (cap_last) begin
         ones_cnt <= pop_nxt;
      end
   end
`endif

endmodule

// File: tb/tb_truth_table_scanner.sv
// Self-checking bench for truth_table_scanner: directed scenarios plus random
// evaluator functions and masks against a behavioural scan model.
module tb_truth_table_scanner;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       start0 = 1'b0, start2 = 1'b0;
   logic [7:0] mask0 = '0, mask2 = '0;
   logic [7:0] fn = '0;
   logic [2:0] vec0, vec2;
   logic       s_in0, s_in2;
   logic       busy0, busy2, done0, done2, match0, match2;
   logic [7:0] tab0, tab2;
   bit         sel = 1'b0;
   int         checks = 0;
   int         failures = 0;

   always #5 clk = ~clk;

   // External evaluator: the sum of minterms selected by fn.
   assign s_in0 = fn[vec0];
   assign s_in2 = fn[vec2];

`ifdef TT_ONES_COUNT_EN
   logic [3:0] ones0, ones2, ones_s;
   assign ones_s = sel ? ones2 : ones0;
`endif

   truth_table_scanner #(.N_VARS(3), .SETTLE(0)) dut0 (
      .clk(clk), .reset(reset), .start(start0), .mask(mask0), .vec(vec0),
      .s_in(s_in0), .busy(busy0), .done(done0), .tt_table(tab0), .match(match0)
`ifdef TT_ONES_COUNT_EN
      , .ones_cnt(ones0)
`endif
   );

   truth_table_scanner #(.N_VARS(3), .SETTLE(2)) dut2 (
      .clk(clk), .reset(reset), .start(start2), .mask(mask2), .vec(vec2),
      .s_in(s_in2), .busy(busy2), .done(done2), .tt_table(tab2), .match(match2)
`ifdef TT_ONES_COUNT_EN
      , .ones_cnt(ones2)
`endif
   );

   logic [2:0] vec_s;
   logic       busy_s, done_s, match_s;
   logic [7:0] tab_s;
   assign vec_s   = sel ? vec2   : vec0;
   assign busy_s  = sel ? busy2  : busy0;
   assign done_s  = sel ? done2  : done0;
   assign match_s = sel ? match2 : match0;
   assign tab_s   = sel ? tab2   : tab0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic drive(input bit s, input logic st, input logic [7:0] m);
      if (s) begin
         start2 = st; mask2 = m;
      end else begin
         start0 = st; mask0 = m;
      end
   endtask

   task automatic check_results(input logic [7:0] f, input logic [7:0] m);
      check("table", 32'(tab_s), 32'(f));
      check("match", 32'(match_s), 32'(f == m));
`ifdef TT_ONES_COUNT_EN
      check("ones_cnt", 32'(ones_s), 32'($countones(f)));
`endif
   endtask

   // One full scan on instance s; the mask is inverted right after accept,
   // and optionally start is pulsed again while vec is 3.
   task automatic do_scan(input bit s, input logic [7:0] f, input logic [7:0] m,
                          input bit pulse_again);
      int settle = s ? 2 : 0;
      int len = 8 * (settle + 1);
      @(negedge clk);
      sel = s;
      fn = f;
      drive(s, 1'b1, m);
      @(posedge clk);
      #1;
      drive(s, 1'b0, ~m);
      for (int c = 1; c <= len; c++) begin
         @(negedge clk);
         check("busy", 32'(busy_s), 32'd1);
         check("vec", 32'(vec_s), 32'((c - 1) / (settle + 1)));
         check("done_early", 32'(done_s), 32'd0);
         if (pulse_again && c == 3 * (settle + 1) + 1) drive(s, 1'b1, m ^ 8'h5A);
         else drive(s, 1'b0, ~m);
      end
      @(negedge clk);
      check("done", 32'(done_s), 32'd1);
      check("busy_at_done", 32'(busy_s), 32'd0);
      check_results(f, m);
      @(negedge clk);
      check("done_once", 32'(done_s), 32'd0);
      check("busy_after", 32'(busy_s), 32'd0);
      check("vec_idle", 32'(vec_s), 32'd0);
      check_results(f, m);
   endtask

   initial begin
      logic [7:0] rf, rm;
      bit         rs;
      int         len, p;

      repeat (3) @(negedge clk);
      for (int s = 0; s < 2; s++) begin
         sel = bit'(s);
         #1;
         check("rst_vec", 32'(vec_s), 32'd0);
         check("rst_busy", 32'(busy_s), 32'd0);
         check("rst_done", 32'(done_s), 32'd0);
         check("rst_table", 32'(tab_s), 32'd0);
         check("rst_match", 32'(match_s), 32'd0);
`ifdef TT_ONES_COUNT_EN
         check("rst_ones", 32'(ones_s), 32'd0);
`endif
      end
      reset = 1'b0;

      do_scan(1'b0, 8'hAA, 8'hAA, 1'b0);
      do_scan(1'b0, 8'hAA, 8'hAB, 1'b0);
      do_scan(1'b0, 8'h00, 8'h00, 1'b0);
      do_scan(1'b1, 8'hFF, 8'hFF, 1'b0);
      do_scan(1'b0, 8'hAA, 8'hAA, 1'b1);
      do_scan(1'b1, 8'h3C, 8'h3C, 1'b1);

      // Reset in the middle of a scan aborts without a done pulse.
      @(negedge clk);
      sel = 1'b0; fn = 8'hAA;
      drive(1'b0, 1'b1, 8'hAA);
      @(posedge clk);
      #1;
      drive(1'b0, 1'b0, 8'hAA);
      repeat (5) @(negedge clk);
      check("abort_vec4", 32'(vec_s), 32'd4);
      reset = 1'b1;
      @(negedge clk);
      check("abort_busy", 32'(busy_s), 32'd0);
      check("abort_vec", 32'(vec_s), 32'd0);
      check("abort_table", 32'(tab_s), 32'd0);
      check("abort_done", 32'(done_s), 32'd0);
      reset = 1'b0;
      repeat (10) begin
         @(negedge clk);
         check("abort_no_done", 32'(done_s), 32'd0);
         check("abort_idle", 32'(busy_s), 32'd0);
      end
      do_scan(1'b0, 8'hAA, 8'hAA, 1'b0);

      // start held high: scan, done, one idle cycle, next scan.
      for (int s = 0; s < 2; s++) begin
         @(negedge clk);
         sel = bit'(s); fn = 8'h96;
         len = 8 * ((s == 1) ? 3 : 1);
         drive(bit'(s), 1'b1, 8'h96);
         for (int c = 1; c <= 3 * (len + 2); c++) begin
            @(negedge clk);
            p = (c - 1) % (len + 2);
            check("hold_busy", 32'(busy_s), 32'(p < len));
            check("hold_done", 32'(done_s), 32'(p == len));
            if (p < len) check("hold_vec", 32'(vec_s), 32'(p / ((s == 1) ? 3 : 1)));
            if (p == len) check_results(8'h96, 8'h96);
         end
         drive(bit'(s), 1'b0, 8'h96);
      end

      for (int i = 0; i < 10; i++) begin
         rs = bit'($urandom_range(0, 1));
         rf = 8'($urandom);
         rm = ($urandom_range(0, 1) == 1) ? rf : 8'($urandom);
         do_scan(rs, rf, rm, bit'($urandom_range(0, 1)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
